perf_arbiter: RTL and testbench

//  Shares one perf-counter cmd/rsp port among NREQ requesters (e.g. CPU CFU path, debug).

---
 rtl/perf_arbiter_pkg.sv | 24 ++
 rtl/perf_arbiter_rr_arbiter.sv | 27 ++
 rtl/perf_arbiter.sv | 127 ++++++++++++
 tb/tb_perf_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_arbiter_pkg.sv
// Shared types for the perf-counter port arbiter: perf register map, FSM encoding, latched command.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package perf_arbiter_pkg;

  // Perf unit register map (4-bit command address)
  localparam logic [3:0] PERF_ADDR_RST = 4'h0;
  localparam logic [3:0] PERF_ADDR_EN  = 4'h4;
  localparam logic [3:0] PERF_ADDR_LO  = 4'h8;
  localparam logic [3:0] PERF_ADDR_HI  = 4'hC;

  typedef enum logic [1:0] {
    ARB_DRAIN = 2'd0,
    ARB_IDLE  = 2'd1,
    ARB_ISSUE = 2'd2,
    ARB_WAIT  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [3:0] addr;
    logic       data;
  } perf_cmd_t;

endpackage

// File: rtl/perf_arbiter_rr_arbiter.sv
// Round-robin pick: first requester with req set, searching last+1, last+2, ... mod NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (per-requester request), last (previous winner) -> gnt_valid, gnt_idx.
module perf_arbiter_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic            gnt_valid,
  output logic [GW-1:0]   gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // k = 1 first so the previous winner is considered last
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_valid && req[(int'(last) + k) % NREQ]) begin
        gnt_valid = 1'b1;
        gnt_idx   = GW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/perf_arbiter.sv
// Shares one perf-counter cmd/rsp port among NREQ requesters, round-robin, one transaction in flight.
// Latency: cmd accept -> downstream cmd_valid next cycle; rsp routed to the winner combinationally.
// Backpressure: one outstanding txn; a winner holding rsp ready low stalls all others indefinitely.
// Ports: clk_i/rst_i; s_cmd_* / s_rsp_* per-requester lanes (flattened); m_cmd_* / m_rsp_* to the perf unit.
module perf_arbiter
  import perf_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      s_cmd_valid_i,
  output logic [NREQ-1:0]      s_cmd_ready_o,
  input  logic [4*NREQ-1:0]    s_cmd_addr_i,
  input  logic [NREQ-1:0]      s_cmd_data_i,
  output logic [NREQ-1:0]      s_rsp_valid_o,
  input  logic [NREQ-1:0]      s_rsp_ready_i,
  output logic [32*NREQ-1:0]   s_rsp_data_o,
  output logic                 m_cmd_valid_o,
  input  logic                 m_cmd_ready_i,
  output logic [3:0]           m_cmd_addr_o,
  output logic                 m_cmd_data_o,
  input  logic                 m_rsp_valid_i,
  output logic                 m_rsp_ready_o,
  input  logic [31:0]          m_rsp_data_i
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e    state_q, state_d;
  logic [GW-1:0] last_q;
  logic [GW-1:0] grant_q;
  perf_cmd_t     cmd_q;

  logic          gnt_valid;
  logic [GW-1:0] pick;
  perf_cmd_t     pick_cmd;
  logic          grant_rsp_rdy;
  logic          cmd_accept;
  logic          rsp_done;

  perf_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_rr (
    .req       (s_cmd_valid_i),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (pick)
  );

  // Lane select: command of the current pick, rsp ready of the current owner
  always_comb begin
    pick_cmd      = '0;
    grant_rsp_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(pick)) begin
        pick_cmd.addr = s_cmd_addr_i[4*i +: 4];
        pick_cmd.data = s_cmd_data_i[i];
      end
      if (i == int'(grant_q)) begin
        grant_rsp_rdy = s_rsp_ready_i[i];
      end
    end
  end

  assign cmd_accept = (state_q == ARB_IDLE) && gnt_valid;
  assign rsp_done   = (state_q == ARB_WAIT) && m_rsp_valid_i && grant_rsp_rdy;

  // State register and command latch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_DRAIN;
      last_q  <= GW'(NREQ - 1);
      grant_q <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_accept) begin
        cmd_q   <= pick_cmd;
        grant_q <= pick;
      end
      if (rsp_done) begin
        last_q <= grant_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Perf unit has no reset: wait until it is idle with nothing left to hand back
      ARB_DRAIN: if (m_cmd_ready_i && !m_rsp_valid_i) state_d = ARB_IDLE;
      ARB_IDLE:  if (gnt_valid)                       state_d = ARB_ISSUE;
      ARB_ISSUE: if (m_cmd_ready_i)                   state_d = ARB_WAIT;
      ARB_WAIT:  if (rsp_done)                        state_d = ARB_IDLE;
      default:                                        state_d = ARB_DRAIN;
    endcase
  end

  // Outputs
  always_comb begin
    s_cmd_ready_o = '0;
    s_rsp_valid_o = '0;
    s_rsp_data_o  = '0;
    m_cmd_valid_o = (state_q == ARB_ISSUE);
    m_cmd_addr_o  = cmd_q.addr;
    m_cmd_data_o  = cmd_q.data;
    m_rsp_ready_o = 1'b0;
    case (state_q)
      ARB_DRAIN: m_rsp_ready_o = 1'b1;  // swallow any stale response
      ARB_WAIT:  m_rsp_ready_o = grant_rsp_rdy;
      default:   m_rsp_ready_o = 1'b0;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      if (cmd_accept && i == int'(pick)) begin
        s_cmd_ready_o[i] = 1'b1;
      end
      if (state_q == ARB_WAIT && i == int'(grant_q)) begin
        s_rsp_valid_o[i]         = m_rsp_valid_i;
        s_rsp_data_o[32*i +: 32] = m_rsp_data_i;
      end
    end
  end

endmodule

// File: tb/tb_perf_arbiter.sv
// Directed bench for perf_arbiter: NREQ=2 instance for reset/drain/routing/stall, NREQ=4 for rotation.
// Latency: behavioural perf stub answers two cycles after accepting a command.
// Backpressure: stub refuses commands while busy; bench controls requester rsp ready.
module tb_perf_arbiter;
  import perf_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] perf_val(input logic [3:0] a);
    case (a)
      PERF_ADDR_LO: return 32'h0000_1234;
      PERF_ADDR_HI: return 32'h0000_0001;
      default:      return 32'h0000_0000;
    endcase
  endfunction

  // ---------------- NREQ = 2 instance ----------------
  logic [1:0]  cv2 = '0, cd2 = '0, rr2 = 2'b11;
  logic [7:0]  ca2 = '0;
  logic [1:0]  cr2, rv2;
  logic [63:0] rd2;
  logic        mcv2, mcr2, mcd2, mrv2, mrr2;
  logic [3:0]  mca2;
  logic [31:0] mrd2;

  logic        p2 = 1'b0, sv2 = 1'b0, hold2 = 1'b1;
  logic [3:0]  pa2 = '0;
  logic [31:0] sd2 = '0;

  assign mcr2 = !(p2 | sv2 | hold2);
  assign mrv2 = sv2 | hold2;
  assign mrd2 = hold2 ? 32'hDEAD_BEEF : sd2;

  // Perf stub has no reset, like the real unit
  always @(posedge clk) begin
    if (p2) begin
      p2  <= 1'b0;
      sv2 <= 1'b1;
      sd2 <= perf_val(pa2);
    end else if (sv2 && mrr2) begin
      sv2 <= 1'b0;
    end
    if (mcv2 && mcr2) begin
      p2  <= 1'b1;
      pa2 <= mca2;
    end
  end

  perf_arbiter #(.NREQ(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .s_cmd_valid_i(cv2), .s_cmd_ready_o(cr2), .s_cmd_addr_i(ca2), .s_cmd_data_i(cd2),
    .s_rsp_valid_o(rv2), .s_rsp_ready_i(rr2), .s_rsp_data_o(rd2),
    .m_cmd_valid_o(mcv2), .m_cmd_ready_i(mcr2), .m_cmd_addr_o(mca2), .m_cmd_data_o(mcd2),
    .m_rsp_valid_i(mrv2), .m_rsp_ready_o(mrr2), .m_rsp_data_i(mrd2)
  );

  // ---------------- NREQ = 4 instance ----------------
  logic [3:0]   cv4 = '0, cd4 = '0, rr4 = 4'hF;
  logic [15:0]  ca4 = 16'h4444;
  logic [3:0]   cr4, rv4;
  logic [127:0] rd4;
  logic         mcv4, mcr4, mcd4, mrv4, mrr4;
  logic [3:0]   mca4;
  logic [31:0]  mrd4;

  logic        p4 = 1'b0, sv4 = 1'b0;
  logic [3:0]  pa4 = '0;
  logic [31:0] sd4 = '0;

  assign mcr4 = !(p4 | sv4);
  assign mrv4 = sv4;
  assign mrd4 = sd4;

  always @(posedge clk) begin
    if (p4) begin
      p4  <= 1'b0;
      sv4 <= 1'b1;
      sd4 <= perf_val(pa4);
    end else if (sv4 && mrr4) begin
      sv4 <= 1'b0;
    end
    if (mcv4 && mcr4) begin
      p4  <= 1'b1;
      pa4 <= mca4;
    end
  end

  perf_arbiter #(.NREQ(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .s_cmd_valid_i(cv4), .s_cmd_ready_o(cr4), .s_cmd_addr_i(ca4), .s_cmd_data_i(cd4),
    .s_rsp_valid_o(rv4), .s_rsp_ready_i(rr4), .s_rsp_data_o(rd4),
    .m_cmd_valid_o(mcv4), .m_cmd_ready_i(mcr4), .m_cmd_addr_o(mca4), .m_cmd_data_o(mcd4),
    .m_rsp_valid_i(mrv4), .m_rsp_ready_o(mrr4), .m_rsp_data_i(mrd4)
  );

  // Grant logs (accept handshakes seen away from the clock edge)
  int g2[$];
  int g4[$];
  int t4[$];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (!rst && cv2[i] && cr2[i]) g2.push_back(i);
    for (int j = 0; j < 4; j++)
      if (!rst && cv4[j] && cr4[j]) begin
        g4.push_back(j);
        t4.push_back(cyc);
      end
  end

  // ---------------- NREQ=2 helpers ----------------
  task automatic issue(input int r, input logic [3:0] a, input logic d);
    int k;
    @(posedge clk) #1;
    cv2[r] = 1'b1;
    ca2[4*r +: 4] = a;
    cd2[r] = d;
    k = 0;
    @(negedge clk);
    while (!cr2[r] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accept", 64'(cr2), 64'd1 << r);
    @(posedge clk) #1;
    cv2[r] = 1'b0;
    @(negedge clk);
    check("m_cmd_valid", 64'(mcv2), 64'd1);
    check("m_cmd_addr", 64'(mca2), 64'(a));
    check("m_cmd_data", 64'(mcd2), 64'(d));
  endtask

  task automatic get_rsp(input int r, input logic [31:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    while (rv2 == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rsp_valid", 64'(rv2), 64'd1 << r);
    check("rsp_lane", 64'(rd2[32*r +: 32]), 64'(exp));
    check("rsp_other_lane", 64'(rd2[32*(1-r) +: 32]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;

    // ---- 1: reset with perf stub stuck in RSP ----
    cv2 = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_cmd_ready", 64'(cr2), 64'd0);
    check("rst_s_rsp_valid", 64'(rv2), 64'd0);
    check("rst_s_rsp_data", rd2, 64'd0);
    check("rst_m_cmd_valid", 64'(mcv2), 64'd0);
    check("rst_m_cmd_addr", 64'(mca2), 64'd0);
    check("rst_m_cmd_data", 64'(mcd2), 64'd0);
    check("rst_m_rsp_ready", 64'(mrr2), 64'd1);
    check("rst4_s_cmd_ready", 64'(cr4), 64'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_m_rsp_ready", 64'(mrr2), 64'd1);
      check("drain_s_cmd_ready", 64'(cr2), 64'd0);
      check("drain_s_rsp_valid", 64'(rv2), 64'd0);
      check("drain_state", 64'(dut2.state_q), 64'(ARB_DRAIN));
    end
    @(posedge clk) #1;
    hold2 = 1'b0;
    cv2 = 2'b00;
    @(negedge clk);
    check("drain_hold_last", 64'(dut2.state_q), 64'(ARB_DRAIN));
    @(negedge clk);
    check("drain_to_idle", 64'(dut2.state_q), 64'(ARB_IDLE));
    check("idle_m_rsp_ready", 64'(mrr2), 64'd0);

    // ---- 2: single transactions on each requester ----
    issue(0, PERF_ADDR_LO, 1'b0);
    get_rsp(0, 32'h0000_1234);
    issue(1, PERF_ADDR_EN, 1'b1);
    get_rsp(1, 32'h0000_0000);

    // ---- 3: both requesting, alternation ----
    @(posedge clk) #1;
    g2.delete();
    ca2 = 8'h84;
    cd2 = 2'b00;
    cv2 = 2'b11;
    k = 0;
    while (g2.size() < 8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk) #1;
    cv2 = 2'b00;
    repeat (6) @(posedge clk);
    check("rr_count", 64'(g2.size()), 64'd8);
    for (int i = 0; i < 8 && i < g2.size(); i++)
      check("rr_order", 64'(g2[i]), 64'(i % 2));

    // ---- 4: requester 1 stalls its response ----
    rr2 = 2'b01;
    issue(1, PERF_ADDR_LO, 1'b0);
    @(posedge clk) #1;
    cv2[0] = 1'b1;
    ca2[3:0] = PERF_ADDR_EN;
    get_rsp(1, 32'h0000_1234);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_m_rsp_ready", 64'(mrr2), 64'd0);
      check("stall_state", 64'(dut2.state_q), 64'(ARB_WAIT));
      check("stall_s_cmd_ready", 64'(cr2), 64'd0);
    end
    @(posedge clk) #1;
    rr2 = 2'b11;
    issue(0, PERF_ADDR_EN, 1'b0);
    get_rsp(0, 32'h0000_0000);

    // ---- 5: reset while a response is pending ----
    issue(0, PERF_ADDR_LO, 1'b0);
    @(posedge clk) #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstw_s_rsp_valid", 64'(rv2), 64'd0);
      check("rstw_m_rsp_ready", 64'(mrr2), 64'd1);
    end
    @(posedge clk) #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_after_s_rsp_valid", 64'(rv2), 64'd0);
    end
    check("rstw_swallowed", 64'(mrv2), 64'd0);
    issue(0, PERF_ADDR_HI, 1'b0);
    get_rsp(0, 32'h0000_0001);

    // ---- 6: NREQ=4, all valid, back to back ----
    @(posedge clk) #1;
    g4.delete();
    t4.delete();
    cv4 = 4'hF;
    k = 0;
    while (g4.size() < 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk) #1;
    cv4 = 4'h0;
    check("rr4_count", 64'(g4.size()), 64'd5);
    for (int i = 0; i < 5 && i < g4.size(); i++)
      check("rr4_order", 64'(g4[i]), 64'(i % 4));
    for (int i = 1; i < 5 && i < t4.size(); i++)
      check("rr4_gap", 64'(t4[i] - t4[i-1]), 64'd4);
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
